// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: DEPTH-entry circular buffer of {instr, pc, pc_plus4}.
// Optional FETCHQ_BYPASS_EN adds a combinational fetch-to-decode path while the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [31:0]              if_instr,
    input  logic [15:0]              if_pc,
    input  logic [15:0]              if_pc_plus4,
    input  logic                     pc_src,
    output logic                     pc_write_zero,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_instr,
    output logic [15:0]              id_pc,
    output logic [15:0]              id_pc_plus4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;

    logic          mem_valid;
    logic          byp_hit;
    logic          full;
    logic          pop;
    logic          pop_mem;
    logic          push;
    logic          ovf_hit;
    logic [63:0]   head;

    // Decode handshake: an entry transfers on any cycle where id_valid && id_ready;
    // id_valid never depends on id_ready and the head holds steady until it transfers.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        mem_valid = (count_q != '0);
        byp_hit   = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp_hit   = !mem_valid && if_valid && !pc_src;
`endif
        id_valid  = mem_valid || byp_hit;
        if (byp_hit) begin
            {id_instr, id_pc, id_pc_plus4} = {if_instr, if_pc, if_pc_plus4};
        end else begin
            {id_instr, id_pc, id_pc_plus4} = head;
        end

        pop     = id_valid && id_ready;
        pop_mem = mem_valid && id_ready;
        full    = (count_q == CW'(DEPTH));
        // A bypassed triple accepted by decode is never written.
        push    = if_valid && !pc_src && (!full || pop) && !(byp_hit && id_ready);
        ovf_hit = if_valid && !pc_src && full && !pop;

        if (pc_src) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_mem);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop_mem);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | ovf_hit;
            if (push) begin
                mem_q[wr_ptr_q] <= {if_instr, if_pc, if_pc_plus4};
            end
        end
    end

    // One-entry margin covers the triple already in flight from instruction memory.
    assign pc_write_zero = (count_q >= CW'(DEPTH - 1));
    assign count         = count_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random traffic,
// with a reference queue of expected head triples.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus4;
    logic        pc_src;
    logic        pc_write_zero;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus4;
    logic [2:0]  count;
    logic        overflow_err;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .pc_src       (pc_src),
        .pc_write_zero(pc_write_zero),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc_plus4  (id_pc_plus4),
        .count        (count),
        .overflow_err (overflow_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [63:0] exp_q[$];
    int          m_count;
    bit          m_ovf;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_count", 64'(count), 64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_pc_write_zero", 64'(pc_write_zero), 64'd0);
        check("rst_overflow_err", 64'(overflow_err), 64'd0);
        check("rst_id_fields", {id_instr, id_pc, id_pc_plus4}, 64'd0);
    endtask

    // One cycle: drive inputs just after an edge, check outputs, advance model at the next edge.
    task automatic cycle(input logic v, input logic [15:0] pc, input logic rdy,
                         input logic src, input logic rst);
        logic [31:0] ins;
        logic [63:0] trip;
        logic [63:0] head;
        bit          byp;
        bit          exp_valid;
        bit          m_pop;
        bit          was_full;
        ins         = $urandom;
        trip        = {ins, pc, pc + 16'd4};
        if_valid    = v;
        if_instr    = ins;
        if_pc       = pc;
        if_pc_plus4 = pc + 16'd4;
        id_ready    = rdy;
        pc_src      = src;
        reset       = rst;
        #1;
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = (m_count == 0) && v && !src;
`endif
        exp_valid = (m_count != 0) || byp;
        check("id_valid", 64'(id_valid), 64'(exp_valid));
        check("count", 64'(count), 64'(m_count));
        check("pc_write_zero", 64'(pc_write_zero), 64'(m_count >= DEPTH - 1));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
        if (exp_valid) begin
            head = byp ? trip : exp_q[0];
            check("head", {id_instr, id_pc, id_pc_plus4}, head);
        end
        m_pop    = exp_valid && rdy;
        was_full = (m_count == DEPTH);
        if (rst) begin
            model_reset();
        end else if (src) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (m_pop && !byp) begin
                void'(exp_q.pop_front());
                m_count--;
            end
            if (v && !(byp && rdy)) begin
                if (!was_full || m_pop) begin
                    exp_q.push_back(trip);
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pc;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        if_valid    = 1'b0;
        if_instr    = '0;
        if_pc       = '0;
        if_pc_plus4 = '0;
        pc_src      = 1'b0;
        id_ready    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();

        // three pushes with decode always ready, then drain
        cycle(1, 16'h0000, 1, 0, 0);
        cycle(1, 16'h0004, 1, 0, 0);
        cycle(1, 16'h0008, 1, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);

        // fill with decode stalled, then drop one while full
        cycle(1, 16'h0000, 0, 0, 0);
        cycle(1, 16'h0004, 0, 0, 0);
        cycle(1, 16'h0008, 0, 0, 0);
        cycle(1, 16'h000C, 0, 0, 0);
        cycle(1, 16'h0FF0, 0, 0, 0);
        // full: pop and push in the same cycle
        cycle(1, 16'h0010, 1, 0, 0);
        cycle(0, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 16'h0000, 1, 0, 0);

        // flush with two entries queued and a triple in the flush cycle
        cycle(1, 16'h0020, 0, 0, 0);
        cycle(1, 16'h0024, 0, 0, 0);
        cycle(1, 16'h0040, 0, 1, 0);
        cycle(1, 16'h0100, 0, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);

        // reset with three queued, overflow set, and a flush in the same cycle
        cycle(1, 16'h0200, 0, 0, 0);
        cycle(1, 16'h0204, 0, 0, 0);
        cycle(1, 16'h0208, 0, 0, 0);
        cycle(1, 16'h020C, 1, 1, 1);
        reset    = 1'b0;
        if_valid = 1'b0;
        pc_src   = 1'b0;
        id_ready = 1'b0;
        #1;
        check_reset_outputs();

        // random traffic
        pc = 16'h1000;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
            pc = pc + 16'd4;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
